lru_finder: RTL and testbench



---
 rtl/lru_pkg.sv | 13 +
 rtl/lru_finder_list_update.sv | 25 ++
 rtl/lru_finder.sv | 39 +++
 tb/tb_lru_finder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/lru_pkg.sv
// Shared constants and types for the four-entry LRU buffer tracker.
// A recency list is packed with slot0 (LRU) in the low bits, slot3 (MRU) in the high bits.
package lru_pkg;

    localparam int NUM_BUF = 4;
    localparam int BUF_W   = 2;

    typedef logic [BUF_W-1:0] buf_num_t;
    typedef buf_num_t [NUM_BUF-1:0] lru_list_t;

    localparam lru_list_t LRU_RESET_ORDER = {2'd3, 2'd2, 2'd1, 2'd0};

endpackage

// File: rtl/lru_finder_list_update.sv
// Combinational next-list logic: moves the promoted buffer to MRU and closes the gap it leaves.
module lru_list_update
    import lru_pkg::*;
(
    input  lru_list_t list_i,
    input  buf_num_t  promote_i,
    output lru_list_t list_o
);

    logic seen;

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        seen   = 1'b0;
        list_o = list_i;
        for (int i = 0; i < NUM_BUF - 1; i++) begin
            seen = seen | (list_i[i] == promote_i);
            if (seen) begin
                list_o[i] = list_i[i + 1];
            end
        end
        list_o[NUM_BUF - 1] = promote_i;
    end

endmodule

// File: rtl/lru_finder.sv
// LRU tracker for a four-buffer pool: references promote a buffer to MRU, requests grant and promote the LRU.
module lru_finder
    import lru_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     new_buf_req,
    input  buf_num_t ref_buf_numbr,
    output buf_num_t buf_num_replc
);

    lru_list_t list_q, list_d;
    buf_num_t  replc_q, replc_d;
    buf_num_t  promote;

    // A request ignores ref_buf_numbr entirely, so an X there never reaches the list.
    assign promote = new_buf_req ? list_q[0] : ref_buf_numbr;
    assign replc_d = new_buf_req ? list_q[0] : replc_q;

    lru_list_update u_list_update (
        .list_i    (list_q),
        .promote_i (promote),
        .list_o    (list_d)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            list_q  <= LRU_RESET_ORDER;
            replc_q <= '0;
        end else begin
            list_q  <= list_d;
            replc_q <= replc_d;
        end
    end

    assign buf_num_replc = replc_q;

endmodule

// File: tb/tb_lru_finder.sv
// Self-checking bench for lru_finder: directed recency sequences plus random traffic against a queue model.
module tb_lru_finder;

    logic       clk;
    logic       rst_n;
    logic       new_buf_req;
    logic [1:0] ref_buf_numbr;
    logic [1:0] buf_num_replc;

    int checks;
    int errors;
    int model[$];
    logic [1:0] exp_grant;

    lru_finder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .new_buf_req   (new_buf_req),
        .ref_buf_numbr (ref_buf_numbr),
        .buf_num_replc (buf_num_replc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        model = {0, 1, 2, 3};
        exp_grant = 2'd0;
    endfunction

    // Move buffer b to the MRU end of the recency queue.
    function automatic void model_touch(input int b);
        for (int i = 0; i < model.size(); i++) begin
            if (model[i] == b) begin
                model.delete(i);
                break;
            end
        end
        model.push_back(b);
    endfunction

    // One clock cycle: drive, let the edge pass, update model, compare output.
    task automatic cycle(input logic req, input logic [1:0] r, output logic [1:0] got);
        new_buf_req   = req;
        ref_buf_numbr = req ? 2'bxx : r;
        @(posedge clk);
        #1;
        if (req) begin
            exp_grant = 2'(model[0]);
            model_touch(model[0]);
        end else begin
            model_touch(int'(r));
        end
        got = buf_num_replc;
        checks++;
        if (buf_num_replc !== exp_grant) begin
            errors++;
            $display("FAIL cycle req=%0b ref=%0d: buf_num_replc=%b expected=%b", req, r, buf_num_replc, exp_grant);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        new_buf_req = 1'b0;
        ref_buf_numbr = 2'd0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic req4(input string name, input int e0, input int e1, input int e2, input int e3);
        int exp_seq[4];
        logic [1:0] got;
        exp_seq = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 2'd0, got);
            checks++;
            if (got !== 2'(exp_seq[i])) begin
                errors++;
                $display("FAIL %s grant%0d: got=%b expected=%0d", name, i, got, exp_seq[i]);
            end
        end
    endtask

    task automatic refs(input int seq[$]);
        logic [1:0] got;
        foreach (seq[i]) cycle(1'b0, 2'(seq[i]), got);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        new_buf_req = 1'b0;
        ref_buf_numbr = 2'd0;
        model_reset();
        #12;
        checks++;
        if (buf_num_replc !== 2'd0) begin
            errors++;
            $display("FAIL reset_output: got=%b expected=00", buf_num_replc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        req4("reset_rotation", 0, 1, 2, 3);
    endtask

    task automatic test_plan();
        apply_reset();
        refs('{0, 1, 0, 3, 2});
        req4("refs_01032", 1, 0, 3, 2);
        refs('{0});
        req4("ref0", 1, 3, 2, 0);
        refs('{2});
        req4("ref2", 1, 3, 0, 2);
        refs('{1});
        req4("ref1", 3, 0, 2, 1);
        refs('{1});
        req4("ref1_mru_noop", 3, 0, 2, 1);
        refs('{3});
        req4("ref3", 0, 2, 1, 3);
        refs('{0});
        req4("ref0_again", 2, 1, 3, 0);
    endtask

    task automatic test_random();
        logic [1:0] got;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), got);
        end
    endtask

    task automatic test_back_to_back_after_refs();
        logic [1:0] got;
        for (int i = 0; i < 20; i++) cycle(1'b0, 2'($urandom_range(0, 3)), got);
        for (int i = 0; i < 8; i++) cycle(1'b1, 2'd0, got);
    endtask

    task automatic test_async_reset();
        logic [1:0] got;
        refs('{3, 1});
        cycle(1'b1, 2'd0, got);
        cycle(1'b1, 2'd0, got);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (buf_num_replc !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_output: got=%b expected=00", buf_num_replc);
        end
        new_buf_req = 1'b1;
        ref_buf_numbr = 2'bxx;
        @(posedge clk);
        #1;
        checks++;
        if (buf_num_replc !== 2'd0) begin
            errors++;
            $display("FAIL reset_held_over_edge: got=%b expected=00", buf_num_replc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        req4("post_reset_rotation", 0, 1, 2, 3);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_plan();
        test_random();
        test_back_to_back_after_refs();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
